// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_pkg
//  Purpose  : Shared definitions for the multicycle RISC-V control unit:
//             FSM state encodings, major opcodes, ALU operation codes,
//             immediate-format select codes and the ALU-op class used
//             between the FSM and the ALU decoder.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

   // FSM states. The encoding is exposed on state_o, so keep it stable.
   // S_JALR / S_JALRLINK are only reachable when JALR_EN is defined.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11,
      S_ILLEGAL  = 4'd12,
      S_JALR     = 4'd13,
      S_JALRLINK = 4'd14
   } state_t;

   // Operation class handed from the FSM to the ALU decoder.
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   // Major opcodes (instr[6:0]).
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_rtype  = 7'b0110011;
   localparam logic [6:0] c_op_itype  = 7'b0010011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_lui    = 7'b0110111;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;

   // ALU operation codes (low 4 bits of alucontrol).
   localparam logic [3:0] c_alu_add  = 4'd0;
   localparam logic [3:0] c_alu_sub  = 4'd1;
   localparam logic [3:0] c_alu_and  = 4'd2;
   localparam logic [3:0] c_alu_or   = 4'd3;
   localparam logic [3:0] c_alu_xor  = 4'd4;
   localparam logic [3:0] c_alu_slt  = 4'd5;
   localparam logic [3:0] c_alu_sltu = 4'd6;
   localparam logic [3:0] c_alu_sll  = 4'd7;
   localparam logic [3:0] c_alu_srl  = 4'd8;
   localparam logic [3:0] c_alu_sra  = 4'd9;

   // Immediate format select codes.
   localparam logic [2:0] c_imm_i = 3'b000;
   localparam logic [2:0] c_imm_s = 3'b001;
   localparam logic [2:0] c_imm_b = 3'b010;
   localparam logic [2:0] c_imm_j = 3'b011;
   localparam logic [2:0] c_imm_u = 3'b100;

   // Immediate format depends only on the opcode; unknown opcodes fall back
   // to the I format, which is harmless because they never write anything.
   function automatic logic [2:0] imm_sel(input logic [6:0] op);
      logic [2:0] sel;
      sel = c_imm_i;
      case (op)
         c_op_store:  sel = c_imm_s;
         c_op_branch: sel = c_imm_b;
         c_op_jal:    sel = c_imm_j;
         c_op_lui:    sel = c_imm_u;
         default:     sel = c_imm_i;
      endcase
      return sel;
   endfunction

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : mc_alu_decoder
//  Purpose  : Combinational ALU operation decode. Forced ADD/SUB for address,
//             PC and compare work; otherwise decoded from funct3/funct7[5].
//  Ports    : aluop      in  2  operation class from the FSM
//             funct3     in  3  instr[14:12]
//             funct7b5   in  1  instr[30]
//             opb5       in  1  instr[5] (1 = R-type, 0 = I-type)
//             alucontrol out 4  ALU operation code
//  Revision : 1.0 - initial release
// ============================================================================
module mc_alu_decoder
   import mc_ctrl_pkg::*;
(
   input  aluop_t       aluop,
   input  logic [2:0]   funct3,
   input  logic         funct7b5,
   input  logic         opb5,
   output logic [3:0]   alucontrol
);

   always_comb begin
      alucontrol = c_alu_add;
      case (aluop)
         ALUOP_ADD: alucontrol = c_alu_add;
         ALUOP_SUB: alucontrol = c_alu_sub;
         default: begin
            case (funct3)
               // funct7[5] only means SUB for register-register forms;
               // for addi it is just an immediate bit.
               3'b000:  alucontrol = (opb5 && funct7b5) ? c_alu_sub : c_alu_add;
               3'b001:  alucontrol = c_alu_sll;
               3'b010:  alucontrol = c_alu_slt;
               3'b011:  alucontrol = c_alu_sltu;
               3'b100:  alucontrol = c_alu_xor;
               // srai carries funct7[5] in the immediate, so no opb5 gate.
               3'b101:  alucontrol = funct7b5 ? c_alu_sra : c_alu_srl;
               3'b110:  alucontrol = c_alu_or;
               default: alucontrol = c_alu_and;
            endcase
         end
      endcase
   end

endmodule : mc_alu_decoder
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Moore-style control FSM for a multicycle RV32I datapath.
//             Optional JALR support is enabled by defining JALR_EN.
//  Params   : MEM_WAIT  1 = memory states wait on mem_ready, 0 = ignore it
//             ALUCTRL_W width of alucontrol (>= 4, zero-extended)
//  Ports    : clk, reset          clock / synchronous active-high reset
//             instr[31:0]         instruction register
//             zero, lt, ltu       ALU compare flags
//             mem_ready           memory access completes this cycle
//             pcwrite, adrsrc, memwrite, irwrite, regwrite   datapath strobes
//             resultsrc, alusrca, alusrcb, immsrc            mux selects
//             alucontrol          ALU operation code
//             illegal_instr       sticky illegal-opcode flag
//             state_o             current FSM state (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_WAIT  = 1,
   parameter int ALUCTRL_W = 4
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          instr,
   input  logic                 zero,
   input  logic                 lt,
   input  logic                 ltu,
   input  logic                 mem_ready,
   output logic                 pcwrite,
   output logic                 adrsrc,
   output logic                 memwrite,
   output logic                 irwrite,
   output logic                 regwrite,
   output logic [1:0]           resultsrc,
   output logic [1:0]           alusrca,
   output logic [1:0]           alusrcb,
   output logic [2:0]           immsrc,
   output logic [ALUCTRL_W-1:0] alucontrol,
   output logic                 illegal_instr,
   output logic [3:0]           state_o
);

   state_t      r_state;
   state_t      w_next;
   logic        r_illegal;

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic        w_ready;
   logic        w_taken;
   aluop_t      w_aluop;
   logic [3:0]  w_alu;

   logic        w_pcwrite;
   logic        w_adrsrc;
   logic        w_memwrite;
   logic        w_irwrite;
   logic        w_regwrite;
   logic [1:0]  w_resultsrc;
   logic [1:0]  w_alusrca;
   logic [1:0]  w_alusrcb;

   // Register fields are decoded by the datapath, not here.
   logic        w_unused;
   assign w_unused = &{1'b0, instr[31], instr[29:15], instr[11:7]};

   assign w_opcode = instr[6:0];
   assign w_funct3 = instr[14:12];
   assign w_ready  = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

   // Branch condition; funct3 010/011 are not branches and never take.
   always_comb begin
      w_taken = 1'b0;
      case (w_funct3)
         3'b000:  w_taken = zero;
         3'b001:  w_taken = ~zero;
         3'b100:  w_taken = lt;
         3'b101:  w_taken = ~lt;
         3'b110:  w_taken = ltu;
         3'b111:  w_taken = ~ltu;
         default: w_taken = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // State register and sticky illegal flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_next;
         if (w_next == S_ILLEGAL) begin
            r_illegal <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state and per-state controls
   // ------------------------------------------------------------------
   always_comb begin
      w_next      = r_state;
      w_pcwrite   = 1'b0;
      w_adrsrc    = 1'b0;
      w_memwrite  = 1'b0;
      w_irwrite   = 1'b0;
      w_regwrite  = 1'b0;
      w_resultsrc = 2'b00;
      w_alusrca   = 2'b00;
      w_alusrcb   = 2'b00;
      w_aluop     = ALUOP_ADD;

      case (r_state)
         S_FETCH: begin
            // PC + 4 goes straight from the ALU result into the PC.
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
            if (w_ready) begin
               w_irwrite = 1'b1;
               w_pcwrite = 1'b1;
               w_next    = S_DECODE;
            end
         end
         S_DECODE: begin
            // Precompute OldPC + imm as the branch/JAL target into ALUOut.
            w_alusrca = 2'b01;
            w_alusrcb = 2'b01;
            case (w_opcode)
               c_op_load,
               c_op_store:  w_next = S_MEMADR;
               c_op_rtype:  w_next = S_EXECR;
               c_op_itype:  w_next = S_EXECI;
               c_op_branch: w_next = S_BRANCH;
               c_op_jal:    w_next = S_JAL;
               c_op_lui:    w_next = S_LUI;
`ifdef JALR_EN
               c_op_jalr:   w_next = S_JALR;
`endif
               default:     w_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            w_alusrca = 2'b10;
            w_alusrcb = 2'b01;
            w_next    = (w_opcode == c_op_load) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            w_adrsrc = 1'b1;
            if (w_ready) begin
               w_next = S_MEMWB;
            end
         end
         S_MEMWB: begin
            w_resultsrc = 2'b01;
            w_regwrite  = 1'b1;
            w_next      = S_FETCH;
         end
         S_MEMWRITE: begin
            w_adrsrc   = 1'b1;
            w_memwrite = 1'b1;
            if (w_ready) begin
               w_next = S_FETCH;
            end
         end
         S_EXECR: begin
            w_alusrca = 2'b10;
            w_alusrcb = 2'b00;
            w_aluop   = ALUOP_FUNCT;
            w_next    = S_ALUWB;
         end
         S_EXECI: begin
            w_alusrca = 2'b10;
            w_alusrcb = 2'b01;
            w_aluop   = ALUOP_FUNCT;
            w_next    = S_ALUWB;
         end
         S_ALUWB: begin
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_BRANCH: begin
            // ALUOut still holds the target from DECODE; the SUB only
            // produces the compare flags.
            w_alusrca = 2'b10;
            w_alusrcb = 2'b00;
            w_aluop   = ALUOP_SUB;
            if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
               w_next = S_ILLEGAL;
            end else begin
               w_pcwrite = w_taken;
               w_next    = S_FETCH;
            end
         end
         S_JAL: begin
            // PC <= target (ALUOut); ALU forms OldPC + 4 for the link write.
            w_alusrca = 2'b01;
            w_alusrcb = 2'b10;
            w_pcwrite = 1'b1;
            w_next    = S_ALUWB;
         end
         S_LUI: begin
            w_alusrca = 2'b11;
            w_alusrcb = 2'b01;
            w_next    = S_ALUWB;
         end
         S_ILLEGAL: begin
            w_next = S_ILLEGAL;
         end
`ifdef JALR_EN
         S_JALR: begin
            // PC <= rs1 + imm directly from the ALU result.
            w_alusrca   = 2'b10;
            w_alusrcb   = 2'b01;
            w_resultsrc = 2'b10;
            w_pcwrite   = 1'b1;
            w_next      = S_JALRLINK;
         end
         S_JALRLINK: begin
            // ALUOut holds rs1 + imm, so the link value is recomputed here.
            w_alusrca   = 2'b01;
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
            w_regwrite  = 1'b1;
            w_next      = S_FETCH;
         end
`endif
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   mc_alu_decoder u_alu_dec (
      .aluop      (w_aluop),
      .funct3     (w_funct3),
      .funct7b5   (instr[30]),
      .opb5       (instr[5]),
      .alucontrol (w_alu)
   );

   generate
      if (ALUCTRL_W > 4) begin : g_alu_ext
         assign alucontrol = {{(ALUCTRL_W-4){1'b0}}, w_alu};
      end else begin : g_alu_exact
         assign alucontrol = w_alu;
      end
   endgenerate

   // Write enables are forced low while reset is held so an interrupted
   // instruction can never complete a write.
   assign pcwrite       = w_pcwrite  & ~reset;
   assign irwrite       = w_irwrite  & ~reset;
   assign memwrite      = w_memwrite & ~reset;
   assign regwrite      = w_regwrite & ~reset;
   assign adrsrc        = w_adrsrc;
   assign resultsrc     = w_resultsrc;
   assign alusrca       = w_alusrca;
   assign alusrcb       = w_alusrcb;
   assign immsrc        = imm_sel(w_opcode);
   assign illegal_instr = r_illegal;
   assign state_o       = r_state;

endmodule : multicycle_control
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1; when 1, memory states wait on mem_ready; when 0, mem_ready is ignored and treated as 1.
REQ-002 SHALL have parameter ALUCTRL_W, default 4, minimum 4; width of alucontrol, zero-extended above 4 bits.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports in this order:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- instr  input  32  instruction register contents
- zero  input  1  ALU result is zero
- lt  input  1  signed less-than flag
- ltu  input  1  unsigned less-than flag
- mem_ready  input  1  memory access completes this cycle
- pcwrite  output  1  PC write enable
- adrsrc  output  1  address mux: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  IR/OldPC write enable
- regwrite  output  1  register file write enable
- resultsrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- alusrca  output  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- alusrcb  output  2  00 rs2, 01 imm, 10 constant 4
- immsrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U
- alucontrol  output  ALUCTRL_W  ALU operation code
- illegal_instr  output  1  sticky illegal-opcode flag
- state_o  output  4  current FSM state, for debug

Function
REQ-004 SHALL implement a Moore FSM with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, ILLEGAL, and (if enabled) JALR.
REQ-005 In FETCH, SHALL drive adrsrc=0, alusrca=00, alusrcb=10, resultsrc=10, and ALU ADD; SHALL assert irwrite and pcwrite only when mem_ready=1; SHALL go to DECODE on mem_ready, otherwise hold.
REQ-006 In DECODE, SHALL drive alusrca=01, alusrcb=01, and ADD (branch target); SHALL dispatch on opcode: 0000011/0100011 to MEMADR, 0110011 to EXECR, 0010011 to EXECI, 1100011 to BRANCH, 1101111 to JAL, 0110111 to LUI, all others to ILLEGAL.
REQ-007 In MEMADR, SHALL drive alusrca=10, alusrcb=01, and ADD; SHALL go to MEMREAD for loads and MEMWRITE for stores.
REQ-008 In MEMREAD, SHALL drive adrsrc=1 and resultsrc=00; SHALL hold until mem_ready, then go to MEMWB.
REQ-009 In MEMWB, SHALL drive resultsrc=01 and regwrite=1, then go to FETCH.
REQ-010 In MEMWRITE, SHALL drive adrsrc=1, resultsrc=00, and memwrite=1 every cycle until mem_ready, then go to FETCH.
REQ-011 EXECR (alusrcb=00) and EXECI (alusrcb=01) SHALL drive alusrca=10, take alucontrol from funct3/funct7[5]/op[5], and go to ALUWB; ALUWB SHALL drive resultsrc=00 and regwrite=1, then go to FETCH.
REQ-012 BRANCH SHALL drive alusrca=10, alusrcb=00, SUB, and resultsrc=00; SHALL assert pcwrite iff taken; taken is defined by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; funct3 010/011 SHALL go to ILLEGAL instead.
REQ-013 JAL SHALL drive alusrca=01, alusrcb=10, ADD, resultsrc=00, and pcwrite=1, then go to ALUWB.
REQ-014 LUI SHALL drive alusrca=11, alusrcb=01, and ADD, then go to ALUWB.
REQ-015 immsrc SHALL be decoded combinationally from opcode in every state.
REQ-016 ILLEGAL SHALL deassert all write enables and set illegal_instr=1; the FSM SHALL stay in ILLEGAL until reset.
REQ-017 Each memory access SHALL take 1 + (cycles mem_ready is low) cycles; minimum latencies SHALL be R/I 4, load 5, store 4, branch 3, JAL 4 cycles.

Reset
REQ-018 reset SHALL set state to FETCH and clear illegal_instr on the next rising edge.
REQ-019 While reset=1, pcwrite, irwrite, memwrite, and regwrite SHALL be 0.
REQ-020 Reset asserted mid-operation SHALL abandon the instruction with no further write enables.

Configuration
REQ-021 With JALR_EN defined, opcode 1100111 SHALL go DECODE->JALR; JALR SHALL drive alusrca=10, alusrcb=01, ADD, resultsrc=10, and pcwrite=1, then go to a link cycle that writes OldPC+4.
REQ-022 Without JALR_EN, opcode 1100111 SHALL go to ILLEGAL.

Structure
REQ-023 State encodings, opcode constants, ALU operation codes, and immsrc codes SHALL live in package mc_ctrl_pkg.
REQ-024 The ALU-operation decode SHALL be a sub-module, mc_alu_decoder (combinational).

Verification
REQ-025 The bench SHALL cover: instr 0x002081B3 (add), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; regwrite=1 only in cycle 4; alucontrol=ADD.
REQ-026 The bench SHALL cover: instr 0x0000A183 (lw), mem_ready low 3 cycles in MEMREAD -> adrsrc=1 for 4 cycles, then one MEMWB cycle with regwrite=1.
REQ-027 The bench SHALL cover: instr 0x00209463 (bne) with zero=0 -> pcwrite=1 in BRANCH; with zero=1 -> pcwrite=0.
REQ-028 The bench SHALL cover: instr 0x0000007F -> ILLEGAL, illegal_instr=1 held, all write enables 0 for 10 cycles, cleared by reset.
REQ-029 The bench SHALL cover: reset asserted during MEMWRITE -> memwrite=0 that cycle and state_o=FETCH the next cycle.
REQ-030 The bench SHALL cover: instr 0x000080E7 (jalr) -> JALR path with JALR_EN defined, ILLEGAL without it.
